grey_10_rx: RTL and testbench

Receive-side decoder and checker for the 5-bit decade grey-code stream produced by the decade grey counter in this design. It samples the code each clock, decodes it to a BCD digit (0-9), and verifies that every code is legal and is the expected successor of the previous one. It acquires lock after a run of correct transitions and regenerates the divided clock. It flags sequence errors and counts them. It sits at the consumer end of any link or ring tap that carries the counter code.

---
 rtl/grey_10_pkg.sv | 40 ++++
 rtl/grey_10_rx_if.sv | 21 ++
 rtl/grey_10_dec.sv | 28 ++
 rtl/grey_10_rx.sv | 130 +++++++++++++
 tb/tb_grey_10_rx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grey_10_pkg.sv
// Shared definitions for the decade grey-code link: the ten legal codes,
// the receiver state encoding and the successor function used by both ends.
package grey_10_pkg;

    localparam logic [4:0] pZERO  = 5'b10001;
    localparam logic [4:0] pONE   = 5'b00001;
    localparam logic [4:0] pTWO   = 5'b00011;
    localparam logic [4:0] pTHREE = 5'b00010;
    localparam logic [4:0] pFOUR  = 5'b00110;
    localparam logic [4:0] pFIVE  = 5'b00100;
    localparam logic [4:0] pSIX   = 5'b01100;
    localparam logic [4:0] pSEVEN = 5'b01000;
    localparam logic [4:0] pEIGHT = 5'b11000;
    localparam logic [4:0] pNINE  = 5'b10000;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } rxState_t;

    // Code that must follow the given digit; 9 wraps back to 0.
    function automatic logic [4:0] nextCode(input logic [3:0] digit);
        logic [4:0] code;
        case (digit)
            4'd0:    code = pONE;
            4'd1:    code = pTWO;
            4'd2:    code = pTHREE;
            4'd3:    code = pFOUR;
            4'd4:    code = pFIVE;
            4'd5:    code = pSIX;
            4'd6:    code = pSEVEN;
            4'd7:    code = pEIGHT;
            4'd8:    code = pNINE;
            default: code = pZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/grey_10_rx_if.sv
// Signal bundle between the grey-code source (master) and the receiver (slave).
interface grey_10_rx_if;
    logic [4:0] i_cnt;
    logic [3:0] o_digit;
    logic       o_valid;
    logic       o_locked;
    logic       o_err;
    logic       o_wrap;
    logic       o_clk_div;
    logic [7:0] o_err_cnt;

    modport master (
        output i_cnt,
        input  o_digit, o_valid, o_locked, o_err, o_wrap, o_clk_div, o_err_cnt
    );

    modport slave (
        input  i_cnt,
        output o_digit, o_valid, o_locked, o_err, o_wrap, o_clk_div, o_err_cnt
    );
endinterface

// File: rtl/grey_10_dec.sv
// Combinational decoder from a 5-bit decade grey code to {legal, BCD digit}.
module grey_10_dec
    import grey_10_pkg::*;
(
    input  logic [4:0] i_code,
    output logic       o_legal,
    output logic [3:0] o_digit
);

    always_comb begin
        o_legal = 1'b1;
        o_digit = 4'd0;
        case (i_code)
            pZERO:   o_digit = 4'd0;
            pONE:    o_digit = 4'd1;
            pTWO:    o_digit = 4'd2;
            pTHREE:  o_digit = 4'd3;
            pFOUR:   o_digit = 4'd4;
            pFIVE:   o_digit = 4'd5;
            pSIX:    o_digit = 4'd6;
            pSEVEN:  o_digit = 4'd7;
            pEIGHT:  o_digit = 4'd8;
            pNINE:   o_digit = 4'd9;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/grey_10_rx.sv
// Decade grey-code receiver: decodes, tracks the expected successor, locks and
// regenerates the divide-by-10 clock. GREY_10_RX_ERRCNT_EN adds the error counter.
module grey_10_rx
    import grey_10_pkg::*;
#(
    parameter int pLOCK_CNT = 4
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    grey_10_rx_if.slave  if_rx
);

    localparam logic [3:0] cLastMatch = 4'(pLOCK_CNT - 1);

    logic [4:0] r_in;
    logic [4:0] r_exp;
    logic [3:0] r_match;
    rxState_t   r_state;
    logic [3:0] r_digit;
    logic       r_valid;
    logic       r_locked;
    logic       r_err;
    logic       r_wrap;
    logic       r_clk_div;

    logic       w_legal;
    logic [3:0] w_digit;
    logic       w_match;

    grey_10_dec u_dec (
        .i_code  (r_in),
        .o_legal (w_legal),
        .o_digit (w_digit)
    );

    assign w_match = w_legal && (r_in == r_exp);

    // A code that breaks lock is never used as a seed and never shown on o_digit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in      <= 5'd0;
            r_exp     <= 5'd0;
            r_match   <= 4'd0;
            r_state   <= HUNT;
            r_digit   <= 4'd0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= 1'b0;
            r_clk_div <= 1'b0;
        end else begin
            r_in    <= if_rx.i_cnt;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        r_exp   <= nextCode(w_digit);
                        r_match <= 4'd0;
                        r_digit <= w_digit;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!w_legal) begin
                        r_state <= HUNT;
                    end else if (w_match) begin
                        r_exp   <= nextCode(w_digit);
                        r_digit <= w_digit;
                        if (r_match == cLastMatch) begin
                            r_state   <= LOCKED;
                            r_locked  <= 1'b1;
                            r_valid   <= 1'b1;
                            r_wrap    <= (w_digit == 4'd0);
                            r_clk_div <= (w_digit >= 4'd5);
                        end else begin
                            r_match <= r_match + 4'd1;
                        end
                    end else begin
                        r_exp   <= nextCode(w_digit);
                        r_match <= 4'd0;
                        r_digit <= w_digit;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        r_exp     <= nextCode(w_digit);
                        r_digit   <= w_digit;
                        r_valid   <= 1'b1;
                        r_wrap    <= (w_digit == 4'd0);
                        r_clk_div <= (w_digit >= 4'd5);
                    end else begin
                        r_err     <= 1'b1;
                        r_locked  <= 1'b0;
                        r_clk_div <= 1'b0;
                        r_state   <= HUNT;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

`ifdef GREY_10_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts lock-breaking events and sticks at 255.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= 8'd0;
        end else if ((r_state == LOCKED) && !w_match && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign if_rx.o_err_cnt = r_err_cnt;
`else
    assign if_rx.o_err_cnt = 8'd0;
`endif

    assign if_rx.o_digit   = r_digit;
    assign if_rx.o_valid   = r_valid;
    assign if_rx.o_locked  = r_locked;
    assign if_rx.o_err     = r_err;
    assign if_rx.o_wrap    = r_wrap;
    assign if_rx.o_clk_div = r_clk_div;

endmodule

// File: tb/tb_grey_10_rx.sv
// Self-checking bench for grey_10_rx: directed scenarios plus a randomized stream
// compared every cycle against a digit-level model of the receiver.
module tb_grey_10_rx;

    localparam int pLockCnt = 4;

    logic clk;
    logic rst;
    grey_10_rx_if bus ();

    grey_10_rx #(.pLOCK_CNT(pLockCnt)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .if_rx (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    logic [4:0] codeTab [10];

    // Model state: the code sitting in the input register plus digit-level history.
    logic [4:0] mIn;
    bit         mSeeded;
    bit         mLocked;
    int         mLast;
    int         mRun;
    int         eDigit, eValid, eErr, eWrap, eClkDiv, eErrCnt;
    bit         modelReady = 1'b0;

    int         curD;
    logic [4:0] lastSent;

    function automatic int codeToDigit(input logic [4:0] c);
        for (int i = 0; i < 10; i++)
            if (codeTab[i] == c) return i;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepModel();
        int d;
        bit valid, err;
        if (rst) begin
            mIn = 5'd0; mSeeded = 0; mLocked = 0; mLast = 0; mRun = 0;
            eDigit = 0; eValid = 0; eErr = 0; eWrap = 0; eClkDiv = 0; eErrCnt = 0;
            modelReady = 1'b1;
        end else begin
            d = codeToDigit(mIn);
            valid = 0;
            err = 0;
            if (mLocked) begin
                if (d == (mLast + 1) % 10) begin
                    mLast = d; eDigit = d; valid = 1;
                end else begin
                    err = 1; mLocked = 0; mSeeded = 0;
`ifdef GREY_10_RX_ERRCNT_EN
                    if (eErrCnt < 255) eErrCnt++;
`endif
                end
            end else if (d < 0) begin
                mSeeded = 0;
            end else if (mSeeded && d == (mLast + 1) % 10) begin
                mRun++; mLast = d; eDigit = d;
                if (mRun >= pLockCnt) begin
                    mLocked = 1; valid = 1;
                end
            end else begin
                mSeeded = 1; mRun = 0; mLast = d; eDigit = d;
            end
            eValid  = valid;
            eErr    = err;
            eWrap   = (valid && eDigit == 0) ? 1 : 0;
            eClkDiv = (mLocked && eDigit >= 5) ? 1 : 0;
            mIn     = bus.i_cnt;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            stepModel();
        end
    end

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("digit",   int'(bus.o_digit),   eDigit);
            checkOutput("valid",   int'(bus.o_valid),   eValid);
            checkOutput("locked",  int'(bus.o_locked),  int'(mLocked));
            checkOutput("err",     int'(bus.o_err),     eErr);
            checkOutput("wrap",    int'(bus.o_wrap),    eWrap);
            checkOutput("clk_div", int'(bus.o_clk_div), eClkDiv);
            checkOutput("err_cnt", int'(bus.o_err_cnt), eErrCnt);
        end
    end

    task automatic applyStimulus(input logic [4:0] code);
        @(negedge clk);
        bus.i_cnt = code;
        lastSent  = code;
    endtask

    task automatic streamNext();
        applyStimulus(codeTab[curD]);
        curD = (curD + 1) % 10;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_digit"},   int'(bus.o_digit),   0);
        checkOutput({tag, "_valid"},   int'(bus.o_valid),   0);
        checkOutput({tag, "_locked"},  int'(bus.o_locked),  0);
        checkOutput({tag, "_err"},     int'(bus.o_err),     0);
        checkOutput({tag, "_wrap"},    int'(bus.o_wrap),    0);
        checkOutput({tag, "_clk_div"}, int'(bus.o_clk_div), 0);
        checkOutput({tag, "_err_cnt"}, int'(bus.o_err_cnt), 0);
    endtask

    int wraps;
    int errCntExp;
    int r;

    initial begin
        codeTab = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                    5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
        rst       = 1'b1;
        bus.i_cnt = 5'd0;
        lastSent  = 5'd0;
        curD      = 0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // Clean lock on 0..4: lock appears together with digit 4
        repeat (6) streamNext();
        checkOutput("lock_before_4", int'(bus.o_locked), 0);
        streamNext();
        checkOutput("lock_at_4_locked", int'(bus.o_locked), 1);
        checkOutput("lock_at_4_digit",  int'(bus.o_digit),  4);
        checkOutput("lock_at_4_valid",  int'(bus.o_valid),  1);

        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            streamNext();
            if (bus.o_wrap === 1'b1) wraps++;
        end
        checkOutput("wrap_count_20", wraps, 2);

        // Single illegal code while locked, then relock after five clean codes
        applyStimulus(5'b11111);
        streamNext();
        streamNext();
        checkOutput("illegal_err",    int'(bus.o_err),    1);
        checkOutput("illegal_locked", int'(bus.o_locked), 0);
`ifdef GREY_10_RX_ERRCNT_EN
        errCntExp = 1;
`else
        errCntExp = 0;
`endif
        checkOutput("illegal_err_cnt", int'(bus.o_err_cnt), errCntExp);
        repeat (4) streamNext();
        checkOutput("relock_not_yet", int'(bus.o_locked), 0);
        streamNext();
        checkOutput("relock_after_5", int'(bus.o_locked), 1);

        // Skipped digit: 3 then 5
        while (curD != 3) streamNext();
        streamNext();
        curD = 5;
        streamNext();
        streamNext();
        streamNext();
        checkOutput("skip_err",   int'(bus.o_err),   1);
        checkOutput("skip_digit", int'(bus.o_digit), 3);

        // Stall: digit 4 repeated
        repeat (12) streamNext();
        while (curD != 4) streamNext();
        streamNext();
        applyStimulus(codeTab[4]);
        streamNext();
        streamNext();
        checkOutput("stall_err",    int'(bus.o_err),    1);
        checkOutput("stall_locked", int'(bus.o_locked), 0);
        checkOutput("stall_digit",  int'(bus.o_digit),  4);

        // Saturation: 0,1,2,3,4,4 forces one error per pass
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 5; k++) applyStimulus(codeTab[k]);
            applyStimulus(codeTab[4]);
        end
        applyStimulus(codeTab[0]);
        applyStimulus(codeTab[1]);
`ifdef GREY_10_RX_ERRCNT_EN
        errCntExp = 255;
`else
        errCntExp = 0;
`endif
        checkOutput("sat_err_cnt", int'(bus.o_err_cnt), errCntExp);

        // Reset in the same cycle as an error
        curD = 2;
        repeat (12) streamNext();
        checkOutput("pre_rst_locked", int'(bus.o_locked), 1);
        applyStimulus(5'b11111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("rst_err");
        rst  = 1'b0;
        curD = 0;

        // Randomized stream with occasional disturbances and resets
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 180) begin
                streamNext();
            end else if (r < 186) begin
                applyStimulus(5'($urandom_range(0, 31)));
            end else if (r < 192) begin
                applyStimulus(lastSent);
            end else if (r < 198) begin
                curD = $urandom_range(0, 9);
                streamNext();
            end else begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
